md_issue_ctrl: RTL and testbench

- Initiator-side controller for the hi/lo multiply/divide unit.
- Accepts decoded MIPS funct requests (MULT, DIV, MTHI, MTLO, MFHI, MFLO) from the execute stage over a valid/ready handshake, and drives the unit's 4-bit function code and operands.
- Models the unit's multi-cycle occupancy for MULT/DIV with a busy counter and stalls later requests until it expires.
- Returns MFHI/MFLO read data over a valid/ready response channel.

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_funct_decode.sv | 30 +++
 rtl/md_issue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_md_issue_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the hi/lo multiply/divide issue controller:
// MDU function codes, MIPS funct encodings and the controller state type.
package md_pkg;

    // Function codes driven to the MDU
    localparam logic [3:0] F_MFHI = 4'b0000;
    localparam logic [3:0] F_MTHI = 4'b0001;
    localparam logic [3:0] F_MFLO = 4'b0010;
    localparam logic [3:0] F_MTLO = 4'b0011;
    localparam logic [3:0] F_NOP  = 4'b0100;
    localparam logic [3:0] F_MULT = 4'b1000;
    localparam logic [3:0] F_DIV  = 4'b1010;

    // MIPS SPECIAL funct field encodings handled by the controller
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MTHI = 6'h11;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MTLO = 6'h13;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_funct_decode.sv
// Combinational decode of a MIPS funct field into an MDU function code
// plus classification flags used by the issue controller.
module md_funct_decode
    import md_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] f_code,
    output logic       is_mf,
    output logic       is_muldiv,
    output logic       illegal
);

    // Map funct to F code; anything unrecognised is flagged illegal and maps to NOP
    always_comb begin
        f_code    = F_NOP;
        is_mf     = 1'b0;
        is_muldiv = 1'b0;
        illegal   = 1'b0;
        unique case (funct)
            FN_MFHI: begin f_code = F_MFHI; is_mf = 1'b1; end
            FN_MFLO: begin f_code = F_MFLO; is_mf = 1'b1; end
            FN_MTHI: f_code = F_MTHI;
            FN_MTLO: f_code = F_MTLO;
            FN_MULT: begin f_code = F_MULT; is_muldiv = 1'b1; end
            FN_DIV:  begin f_code = F_DIV;  is_muldiv = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// Initiator-side issue controller for the hi/lo multiply/divide unit.
// Accepts decoded funct requests, drives registered function code/operands
// to the MDU, models MULT/DIV occupancy and returns MFHI/MFLO read data.
// Optional: define MD_DIV0_TRAP_EN to suppress DIV by zero and pulse div0.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int unsigned N       = 32,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [5:0]   req_funct,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    output logic [3:0]   md_f,
    output logic [N-1:0] md_a,
    output logic [N-1:0] md_b,
    input  logic [N-1:0] md_y,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
`ifdef MD_DIV0_TRAP_EN
    output logic         div0,
`endif
    output logic         err
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

    md_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    md_f_q, md_f_d;
    logic [N-1:0]  md_a_q, md_a_d;
    logic [N-1:0]  md_b_q, md_b_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [N-1:0]  rsp_data_q, rsp_data_d;
    logic          err_q, err_d;
    logic          op_mf_q, op_mf_d;

    logic [3:0]    dec_f;
    logic          dec_is_mf;
    logic          dec_is_muldiv;
    logic          dec_illegal;
    logic          accept;

    md_funct_decode u_decode (
        .funct     (req_funct),
        .f_code    (dec_f),
        .is_mf     (dec_is_mf),
        .is_muldiv (dec_is_muldiv),
        .illegal   (dec_illegal)
    );

    assign req_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;

`ifdef MD_DIV0_TRAP_EN
    logic div0_q, div0_d;
    logic div0_hit;
    assign div0_hit = (dec_f == F_DIV) && (req_b == '0);
    assign div0     = div0_q;
`endif

    // Next-state logic: accept/issue sequencing, occupancy countdown, response hold
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        md_f_d      = F_NOP;
        md_a_d      = md_a_q;
        md_b_d      = md_b_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_data_d  = rsp_data_q;
        err_d       = 1'b0;
        op_mf_d     = op_mf_q;
`ifdef MD_DIV0_TRAP_EN
        div0_d      = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_illegal) begin
                        err_d = 1'b1;
                    end
`ifdef MD_DIV0_TRAP_EN
                    else if (div0_hit) begin
                        div0_d = 1'b1;
                    end
`endif
                    else begin
                        state_d = ISSUE;
                        md_f_d  = dec_f;
                        md_a_d  = req_a;
                        md_b_d  = req_b;
                        op_mf_d = dec_is_mf;
                        // Occupancy is preloaded at accept so ISSUE only has to test for zero
                        if (dec_is_muldiv)
                            cnt_d = (dec_f == F_DIV) ? DIV_CNT : MUL_CNT;
                        else
                            cnt_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (op_mf_q) begin
                    rsp_data_d  = md_y;
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (cnt_q != '0) begin
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, asynchronously reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            md_f_q      <= F_NOP;
            md_a_q      <= '0;
            md_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            op_mf_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_f_q      <= md_f_d;
            md_a_q      <= md_a_d;
            md_b_q      <= md_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            op_mf_q     <= op_mf_d;
        end
    end

`ifdef MD_DIV0_TRAP_EN
    // Divide-by-zero trap pulse register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div0_q <= 1'b0;
        else
            div0_q <= div0_d;
    end
`endif

    assign md_f      = md_f_q;
    assign md_a      = md_a_q;
    assign md_b      = md_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed self-checking bench for md_issue_ctrl with a behavioural hi/lo MDU.
module tb_md_issue_ctrl;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_funct;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  md_f;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic [31:0] md_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        err;
`ifdef MD_DIV0_TRAP_EN
    logic        div0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    md_issue_ctrl #(.N(32), .MUL_LAT(3), .DIV_LAT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_funct (req_funct),
        .req_a     (req_a),
        .req_b     (req_b),
        .md_f      (md_f),
        .md_a      (md_a),
        .md_b      (md_b),
        .md_y      (md_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
`ifdef MD_DIV0_TRAP_EN
        .div0      (div0),
`endif
        .err       (err)
    );

    // Behavioural hi/lo unit: writes on the function code, reads combinationally
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;
    always @(posedge clk) begin
        case (md_f)
            4'b1000: {hi_m, lo_m} <= 64'(md_a) * 64'(md_b);
            4'b1010: if (md_b != 0) begin lo_m <= md_a / md_b; hi_m <= md_a % md_b; end
            4'b0001: hi_m <= md_a;
            4'b0011: lo_m <= md_a;
            default: ;
        endcase
    end
    assign md_y = md_f[1] ? lo_m : hi_m;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a request, count stall cycles until ready, then step past the accept edge
    task automatic send(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        output int waited);
        req_valid = 1'b1;
        req_funct = fn;
        req_a     = a;
        req_b     = b;
        waited    = 0;
        #1;
        while (!req_ready && waited < 40) begin
            tick();
            waited++;
        end
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_funct = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_md_f", 32'(md_f), 32'h4);
        chk("rst_md_a", md_a, 32'h0);
        chk("rst_md_b", md_b, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        reset = 1'b0;
        tick();

        // MTHI then MFHI
        send(FN_MTHI, 32'h55, 32'h0, w);
        chk("mthi_wait", 32'(w), 32'd0);
        chk("mthi_md_f", 32'(md_f), 32'h1);
        chk("mthi_md_a", md_a, 32'h55);
        send(FN_MFHI, 32'h0, 32'h0, w);
        chk("mfhi_wait", 32'(w), 32'd1);
        chk("mfhi_md_f", 32'(md_f), 32'h0);
        chk("mfhi_c1_valid", 32'(rsp_valid), 32'h0);
        tick();
        chk("mfhi_valid", 32'(rsp_valid), 32'h1);
        chk("mfhi_data", rsp_data, 32'h55);

        // MULT 7*6, then MFLO and MFHI
        send(FN_MULT, 32'd7, 32'd6, w);
        chk("mult_wait", 32'(w), 32'd0);
        chk("mult_md_f", 32'(md_f), 32'h8);
        chk("mult_md_a", md_a, 32'd7);
        chk("mult_md_b", md_b, 32'd6);
        chk("mult_c1_ready", 32'(req_ready), 32'h0);
        send(FN_MFLO, 32'h0, 32'h0, w);
        chk("mult_stall", 32'(w), 32'd3);
        tick();
        chk("mult_lo_valid", 32'(rsp_valid), 32'h1);
        chk("mult_lo", rsp_data, 32'd42);
        send(FN_MFHI, 32'h0, 32'h0, w);
        chk("mult_hi_wait", 32'(w), 32'd0);
        tick();
        chk("mult_hi", rsp_data, 32'd0);

        // DIV 17/5
        send(FN_DIV, 32'd17, 32'd5, w);
        chk("div_md_f", 32'(md_f), 32'ha);
        send(FN_MFLO, 32'h0, 32'h0, w);
        chk("div_stall", 32'(w), 32'd4);
        tick();
        chk("div_lo", rsp_data, 32'd3);
        send(FN_MFHI, 32'h0, 32'h0, w);
        tick();
        chk("div_hi", rsp_data, 32'd2);

        // Response back-pressure blocks a queued MFHI
        send(FN_MTHI, 32'hABCD, 32'h0, w);
        send(FN_MFHI, 32'h0, 32'h0, w);
        chk("bp_wait", 32'(w), 32'd1);
        rsp_ready = 1'b0;
        tick();
        req_valid = 1'b1;
        req_funct = FN_MFHI;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready_low", 32'(req_ready), 32'h0);
            chk("bp_data_hold", rsp_data, 32'hABCD);
            tick();
        end
        chk("bp_valid_hold", 32'(rsp_valid), 32'h1);
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 1'b0;
        chk("bp_cleared", 32'(rsp_valid), 32'h0);
        tick();
        chk("bp_second_valid", 32'(rsp_valid), 32'h1);
        chk("bp_second_data", rsp_data, 32'hABCD);

        // Illegal funct, then immediate MTLO
        send(6'h20, 32'h0, 32'h0, w);
        chk("ill_wait", 32'(w), 32'd0);
        chk("ill_err", 32'(err), 32'h1);
        chk("ill_md_f", 32'(md_f), 32'h4);
        chk("ill_ready", 32'(req_ready), 32'h1);
        send(FN_MTLO, 32'h1234, 32'h0, w);
        chk("ill_next_wait", 32'(w), 32'd0);
        chk("ill_err_pulse", 32'(err), 32'h0);
        chk("mtlo_md_f", 32'(md_f), 32'h3);
        tick();

        // Reset drops a pending response
        send(FN_MFLO, 32'h0, 32'h0, w);
        rsp_ready = 1'b0;
        tick();
        chk("pend_data", rsp_data, 32'h1234);
        reset = 1'b1;
        #1;
        chk("rst_pend_valid", 32'(rsp_valid), 32'h0);
        chk("rst_pend_data", rsp_data, 32'h0);
        tick();
        reset = 1'b0;
        rsp_ready = 1'b1;

        // Reset during DIV occupancy
        send(FN_DIV, 32'd100, 32'd7, w);
        chk("div2_wait", 32'(w), 32'd0);
        tick();
        chk("div2_busy_ready", 32'(req_ready), 32'h0);
        chk("div2_busy_md_f", 32'(md_f), 32'h4);
        chk("div2_busy_md_a", md_a, 32'd100);
        reset = 1'b1;
        #1;
        chk("rst_busy_md_f", 32'(md_f), 32'h4);
        chk("rst_busy_md_a", md_a, 32'h0);
        chk("rst_busy_md_b", md_b, 32'h0);
        chk("rst_busy_valid", 32'(rsp_valid), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_busy_ready", 32'(req_ready), 32'h1);
        send(FN_MFLO, 32'h0, 32'h0, w);
        chk("post_rst_wait", 32'(w), 32'd0);
        tick();
        chk("post_rst_lo", rsp_data, 32'd14);

        // Divide by zero
        send(FN_MTLO, 32'h77, 32'h0, w);
`ifdef MD_DIV0_TRAP_EN
        send(FN_DIV, 32'd9, 32'd0, w);
        chk("div0_pulse", 32'(div0), 32'h1);
        chk("div0_md_f", 32'(md_f), 32'h4);
        chk("div0_ready", 32'(req_ready), 32'h1);
        send(FN_MFLO, 32'h0, 32'h0, w);
        chk("div0_wait", 32'(w), 32'd0);
        chk("div0_clear", 32'(div0), 32'h0);
        tick();
        chk("div0_lo_kept", rsp_data, 32'h77);
`else
        send(FN_DIV, 32'd9, 32'd0, w);
        chk("div0_issue_md_f", 32'(md_f), 32'ha);
        chk("div0_issue_md_b", md_b, 32'h0);
        send(FN_MTLO, 32'h5, 32'h0, w);
        chk("div0_issue_stall", 32'(w), 32'd4);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
